// File: rtl/pio_pkg.sv
// Shared PIO definitions: ISR state encoding, shift direction constants and
// the shift-count decode used by both the ISR and the OSR.
package pio_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } isr_state_t;

  localparam logic SHIFT_RIGHT = 1'b1;
  localparam logic SHIFT_LEFT  = 1'b0;

  // A zero shift/threshold field encodes the full register width.
  function automatic logic [31:0] decode_shift(input logic [31:0] sh, input logic [31:0] data_w);
    logic [31:0] res_s;
    if (sh == 32'd0) begin
      res_s = data_w;
    end else begin
      res_s = sh;
    end
    return res_s;
  endfunction

endpackage

// File: rtl/pio_isr_autopush_shift_merge.sv
// Combinational merge-shifter: shifts din into the register from either end.
// Module name pio_shift_merge so the OSR can instantiate the same block.
module pio_shift_merge
  import pio_pkg::*;
#(
  parameter int DATA_W = 32,
  localparam int SH_W  = $clog2(DATA_W),
  localparam int CNT_W = SH_W + 1
) (
  input  logic [DATA_W-1:0] din,
  input  logic [DATA_W-1:0] isr,
  input  logic [CNT_W-1:0]  shift_val,
  input  logic              dir,
  output logic [DATA_W-1:0] new_isr
);

  logic [CNT_W-1:0]  inv_shift_s;
  logic [DATA_W-1:0] din_low_s;
  logic [DATA_W-1:0] left_s;
  logic [DATA_W-1:0] right_s;

  // Same result as slicing the 2*DATA_W concatenation, without the unused half:
  // left keeps the low shift_val bits of din below the shifted ISR, right puts
  // them above it. A full-width shift_val yields din alone in both directions.
  always_comb begin
    inv_shift_s = CNT_W'(DATA_W) - shift_val;
    din_low_s   = (din << inv_shift_s) >> inv_shift_s;
    left_s      = (isr << shift_val) | din_low_s;
    right_s     = (isr >> shift_val) | (din << inv_shift_s);
    if (dir == SHIFT_RIGHT) begin
      new_isr = right_s;
    end else begin
      new_isr = left_s;
    end
  end

endmodule

// File: rtl/pio_isr_autopush.sv
// PIO input shift register with autopush, explicit PUSH and a valid/ready RX port.
// Optional PUSH IFFULL qualifier enabled by defining PIO_ISR_IFFULL_EN.
module pio_isr_autopush
  import pio_pkg::*;
#(
  parameter int DATA_W = 32,
  localparam int SH_W  = $clog2(DATA_W),
  localparam int CNT_W = SH_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              penable,
  input  logic [DATA_W-1:0] din,
  input  logic [SH_W-1:0]   shift,
  input  logic              dir,
  input  logic              do_set,
  input  logic [CNT_W-1:0]  set_count,
  input  logic              do_shift,
  input  logic              do_push,
  input  logic              push_block,
`ifdef PIO_ISR_IFFULL_EN
  input  logic              push_iffull,
`endif
  input  logic              autopush_en,
  input  logic [SH_W-1:0]   push_thresh,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              stall,
  output logic [DATA_W-1:0] dout,
  output logic [CNT_W-1:0]  shift_count
);

  isr_state_t        state_r, state_next_s;
  logic [DATA_W-1:0] isr_r, isr_next_s, merged_s, push_data_s;
  logic [CNT_W-1:0]  count_r, count_next_s, count_sat_s;
  logic [CNT_W-1:0]  shift_val_s, thr_s;
  logic [CNT_W:0]    sum_s;
  logic [DATA_W-1:0] rx_data_r;
  logic              rx_valid_r;
  logic              slot_free_s, push_s, iffull_hold_s;

  pio_shift_merge #(.DATA_W(DATA_W)) u_merge (
    .din       (din),
    .isr       (isr_r),
    .shift_val (shift_val_s),
    .dir       (dir),
    .new_isr   (merged_s)
  );

  // Decode fields, saturate the bit counter and qualify an IFFULL push.
  always_comb begin
    slot_free_s = !rx_valid_r || rx_ready;
    shift_val_s = CNT_W'(decode_shift(32'(shift), 32'(DATA_W)));
    thr_s       = CNT_W'(decode_shift(32'(push_thresh), 32'(DATA_W)));
    sum_s       = {1'b0, count_r} + {1'b0, shift_val_s};
    if (sum_s > (CNT_W + 1)'(DATA_W)) begin
      count_sat_s = CNT_W'(DATA_W);
    end else begin
      count_sat_s = sum_s[CNT_W-1:0];
    end
`ifdef PIO_ISR_IFFULL_EN
    iffull_hold_s = push_iffull && (count_r < thr_s);
`else
    iffull_hold_s = 1'b0;
`endif
  end

  // Action selection and WAIT handling; stall clears in the cycle the push lands.
  always_comb begin
    state_next_s = state_r;
    isr_next_s   = isr_r;
    count_next_s = count_r;
    push_s       = 1'b0;
    push_data_s  = isr_r;
    stall        = 1'b0;
    case (state_r)
      IDLE: begin
        if (!penable) begin
          state_next_s = IDLE;
        end else if (do_set) begin
          isr_next_s   = din;
          count_next_s = set_count;
        end else if (do_push) begin
          if (iffull_hold_s) begin
            state_next_s = IDLE;
          end else if (slot_free_s) begin
            push_s       = 1'b1;
            isr_next_s   = {DATA_W{1'b0}};
            count_next_s = {CNT_W{1'b0}};
          end else if (!push_block) begin
            isr_next_s   = {DATA_W{1'b0}};
            count_next_s = {CNT_W{1'b0}};
          end else begin
            state_next_s = WAIT;
          end
        end else if (do_shift) begin
          isr_next_s   = merged_s;
          count_next_s = count_sat_s;
          if (autopush_en && (count_sat_s >= thr_s)) begin
            if (slot_free_s) begin
              push_s       = 1'b1;
              push_data_s  = merged_s;
              isr_next_s   = {DATA_W{1'b0}};
              count_next_s = {CNT_W{1'b0}};
            end else begin
              state_next_s = WAIT;
            end
          end else begin
            state_next_s = IDLE;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      WAIT: begin
        if (penable && slot_free_s) begin
          push_s       = 1'b1;
          isr_next_s   = {DATA_W{1'b0}};
          count_next_s = {CNT_W{1'b0}};
          state_next_s = IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // ISR, counter and state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      isr_r   <= {DATA_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_next_s;
      isr_r   <= isr_next_s;
      count_r <= count_next_s;
    end
  end

  // RX slot: a new push reloads it even while the old payload is being taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_data_r  <= {DATA_W{1'b0}};
      rx_valid_r <= 1'b0;
    end else if (push_s) begin
      rx_data_r  <= push_data_s;
      rx_valid_r <= 1'b1;
    end else if (rx_valid_r && rx_ready) begin
      rx_valid_r <= 1'b0;
    end else begin
      rx_valid_r <= rx_valid_r;
    end
  end

  assign rx_data     = rx_data_r;
  assign rx_valid    = rx_valid_r;
  assign dout        = isr_r;
  assign shift_count = count_r;

endmodule

// File: tb/tb_pio_isr_autopush.sv
// Directed self-checking bench for pio_isr_autopush (DATA_W=32).
module tb_pio_isr_autopush;

  localparam int DATA_W = 32;
  localparam int SH_W   = 5;
  localparam int CNT_W  = 6;

  logic              clk = 1'b0;
  logic              reset;
  logic              penable;
  logic [DATA_W-1:0] din;
  logic [SH_W-1:0]   shift;
  logic              dir;
  logic              do_set;
  logic [CNT_W-1:0]  set_count;
  logic              do_shift;
  logic              do_push;
  logic              push_block;
`ifdef PIO_ISR_IFFULL_EN
  logic              push_iffull;
`endif
  logic              autopush_en;
  logic [SH_W-1:0]   push_thresh;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              stall;
  logic [DATA_W-1:0] dout;
  logic [CNT_W-1:0]  shift_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pio_isr_autopush #(.DATA_W(DATA_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .penable     (penable),
    .din         (din),
    .shift       (shift),
    .dir         (dir),
    .do_set      (do_set),
    .set_count   (set_count),
    .do_shift    (do_shift),
    .do_push     (do_push),
    .push_block  (push_block),
`ifdef PIO_ISR_IFFULL_EN
    .push_iffull (push_iffull),
`endif
    .autopush_en (autopush_en),
    .push_thresh (push_thresh),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .stall       (stall),
    .dout        (dout),
    .shift_count (shift_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    penable = 1'b1; din = 32'h0; shift = 5'd0; dir = 1'b0;
    do_set = 1'b0; set_count = 6'd0; do_shift = 1'b0; do_push = 1'b0;
    push_block = 1'b0; autopush_en = 1'b0; push_thresh = 5'd0; rx_ready = 1'b0;
`ifdef PIO_ISR_IFFULL_EN
    push_iffull = 1'b0;
`endif
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (dout !== 32'h0) begin errors++; $display("FAIL reset_dout got %h exp 0", dout); end
    checks++; if (shift_count !== 6'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", shift_count); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", rx_valid); end
    checks++; if (rx_data !== 32'h0) begin errors++; $display("FAIL reset_data got %h exp 0", rx_data); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", stall); end
  endtask

  task automatic test_left_shift();
    do_reset();
    dir = 1'b0; shift = 5'd4; din = 32'hA; do_shift = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    do_shift = 1'b0;
    checks++; if (dout !== 32'h00000AAA) begin errors++; $display("FAIL left_dout got %h exp 00000aaa", dout); end
    checks++; if (shift_count !== 6'd12) begin errors++; $display("FAIL left_count got %0d exp 12", shift_count); end
    // penable low: an IN must not change anything
    penable = 1'b0; do_shift = 1'b1; din = 32'hF; tick();
    do_shift = 1'b0; penable = 1'b1;
    checks++; if (dout !== 32'h00000AAA) begin errors++; $display("FAIL penable_dout got %h exp 00000aaa", dout); end
    checks++; if (shift_count !== 6'd12) begin errors++; $display("FAIL penable_count got %0d exp 12", shift_count); end
  endtask

  task automatic test_right_shift();
    do_reset();
    dir = 1'b1; shift = 5'd0; din = 32'hDEADBEEF; do_shift = 1'b1;
    tick();
    checks++; if (dout !== 32'hDEADBEEF) begin errors++; $display("FAIL right32_dout got %h exp deadbeef", dout); end
    checks++; if (shift_count !== 6'd32) begin errors++; $display("FAIL right32_count got %0d exp 32", shift_count); end
    shift = 5'd8; din = 32'h00000011;
    tick();
    do_shift = 1'b0;
    checks++; if (dout !== 32'h11DEADBE) begin errors++; $display("FAIL right8_dout got %h exp 11deadbe", dout); end
    checks++; if (shift_count !== 6'd32) begin errors++; $display("FAIL right8_sat_count got %0d exp 32", shift_count); end
  endtask

  task automatic test_autopush();
    do_reset();
    autopush_en = 1'b1; push_thresh = 5'd8; rx_ready = 1'b1;
    dir = 1'b0; shift = 5'd4; din = 32'h5; do_shift = 1'b1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL auto_stall0 got %b exp 0", stall); end
    tick();
    checks++; if (rx_valid !== 1'b0 || dout !== 32'h5 || shift_count !== 6'd4 || stall !== 1'b0) begin
      errors++; $display("FAIL auto_first got v=%b d=%h c=%0d s=%b exp v=0 d=5 c=4 s=0", rx_valid, dout, shift_count, stall); end
    tick();
    do_shift = 1'b0;
    checks++; if (rx_valid !== 1'b1 || rx_data !== 32'h55) begin
      errors++; $display("FAIL auto_push got v=%b d=%h exp v=1 d=55", rx_valid, rx_data); end
    checks++; if (dout !== 32'h0 || shift_count !== 6'd0 || stall !== 1'b0) begin
      errors++; $display("FAIL auto_clear got d=%h c=%0d s=%b exp 0 0 0", dout, shift_count, stall); end
    tick();
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL auto_drain got %b exp 0", rx_valid); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    autopush_en = 1'b1; push_thresh = 5'd8; rx_ready = 1'b1;
    dir = 1'b0; shift = 5'd8; do_shift = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      din = 32'h11 * i;
      tick();
      checks++; if (rx_valid !== 1'b1 || rx_data !== 32'h11 * i) begin
        errors++; $display("FAIL b2b_%0d got v=%b d=%h exp v=1 d=%h", i, rx_valid, rx_data, 32'h11 * i); end
    end
    do_shift = 1'b0;
  endtask

  task automatic test_block_push();
    do_reset();
    rx_ready = 1'b1; do_set = 1'b1; din = 32'hCAFE; set_count = 6'd16; tick();
    do_set = 1'b0; do_push = 1'b1; tick();
    do_push = 1'b0; rx_ready = 1'b0;
    checks++; if (rx_valid !== 1'b1 || rx_data !== 32'hCAFE) begin
      errors++; $display("FAIL blk_first got v=%b d=%h exp v=1 d=cafe", rx_valid, rx_data); end
    do_set = 1'b1; din = 32'h1234; tick();
    do_set = 1'b0; do_push = 1'b1; push_block = 1'b1; tick();
    for (int i = 0; i < 3; i++) begin
      checks++; if (stall !== 1'b1 || rx_data !== 32'hCAFE || dout !== 32'h1234) begin
        errors++; $display("FAIL blk_wait_%0d got s=%b r=%h d=%h exp s=1 r=cafe d=1234", i, stall, rx_data, dout); end
      tick();
    end
    do_push = 1'b0; rx_ready = 1'b1; #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL blk_release_stall got %b exp 0", stall); end
    tick();
    rx_ready = 1'b0; push_block = 1'b0;
    checks++; if (rx_valid !== 1'b1 || rx_data !== 32'h1234 || stall !== 1'b0) begin
      errors++; $display("FAIL blk_done got v=%b d=%h s=%b exp v=1 d=1234 s=0", rx_valid, rx_data, stall); end
    checks++; if (dout !== 32'h0 || shift_count !== 6'd0) begin
      errors++; $display("FAIL blk_clear got d=%h c=%0d exp 0 0", dout, shift_count); end
  endtask

  task automatic test_noblock_and_reset();
    // slot still holds 0x1234 with rx_ready low
    do_set = 1'b1; din = 32'h77; set_count = 6'd8; tick();
    do_set = 1'b0; do_push = 1'b1; push_block = 1'b0; tick();
    do_push = 1'b0;
    checks++; if (dout !== 32'h0 || shift_count !== 6'd0 || stall !== 1'b0) begin
      errors++; $display("FAIL nb_clear got d=%h c=%0d s=%b exp 0 0 0", dout, shift_count, stall); end
    checks++; if (rx_valid !== 1'b1 || rx_data !== 32'h1234) begin
      errors++; $display("FAIL nb_slot got v=%b d=%h exp v=1 d=1234", rx_valid, rx_data); end
    do_set = 1'b1; din = 32'h99; tick();
    do_set = 1'b0; do_push = 1'b1; push_block = 1'b1; tick();
    do_push = 1'b0;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL nb_wait_stall got %b exp 1", stall); end
    reset = 1'b1; tick(); reset = 1'b0;
    checks++; if (rx_valid !== 1'b0 || stall !== 1'b0 || dout !== 32'h0) begin
      errors++; $display("FAIL wait_reset got v=%b s=%b d=%h exp 0 0 0", rx_valid, stall, dout); end
    push_block = 1'b0;
  endtask

`ifdef PIO_ISR_IFFULL_EN
  task automatic test_iffull();
    do_reset();
    push_thresh = 5'd16; rx_ready = 1'b1;
    do_set = 1'b1; din = 32'hABC; set_count = 6'd12; tick();
    do_set = 1'b0; do_push = 1'b1; push_iffull = 1'b1; tick();
    do_push = 1'b0;
    checks++; if (rx_valid !== 1'b0 || dout !== 32'hABC || shift_count !== 6'd12 || stall !== 1'b0) begin
      errors++; $display("FAIL iffull_hold got v=%b d=%h c=%0d s=%b exp 0 abc 12 0", rx_valid, dout, shift_count, stall); end
    do_set = 1'b1; set_count = 6'd16; tick();
    do_set = 1'b0; do_push = 1'b1; tick();
    do_push = 1'b0; push_iffull = 1'b0;
    checks++; if (rx_valid !== 1'b1 || rx_data !== 32'hABC || dout !== 32'h0) begin
      errors++; $display("FAIL iffull_push got v=%b r=%h d=%h exp 1 abc 0", rx_valid, rx_data, dout); end
  endtask
`endif

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_left_shift();
    test_right_shift();
    test_autopush();
    test_back_to_back();
    test_block_push();
    test_noblock_and_reset();
`ifdef PIO_ISR_IFFULL_EN
    test_iffull();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pio_isr_autopush.md
Name: pio_isr_autopush

Overview:
- Parametrised PIO input shift register (ISR) with autopush, explicit PUSH (block/noblock) and a registered valid/ready push port toward the RX FIFO.
- Sits between the state-machine execute stage (IN/PUSH/MOV-to-ISR) and the RX FIFO.
- Raises stall to the execute stage while a blocking push cannot complete.

Parameters:
- DATA_W, 32: ISR width. Power of two, 8..64.
- SH_W, $clog2(DATA_W): derived localparam; width of shift and threshold fields.
- CNT_W, SH_W+1: derived localparam; width of the bit counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- penable  in  1  state-machine tick enable
- din  in  DATA_W  IN-source data or MOV/SET data
- shift  in  SH_W  shift amount; 0 encodes DATA_W
- dir  in  1  1=shift right, 0=shift left
- do_set  in  1  load ISR from din
- set_count  in  CNT_W  counter value loaded with do_set
- do_shift  in  1  IN operation
- do_push  in  1  explicit PUSH
- push_block  in  1  PUSH blocks when slot busy
- autopush_en  in  1  enable autopush
- push_thresh  in  SH_W  autopush threshold; 0 encodes DATA_W
- rx_data  out  DATA_W  push payload
- rx_valid  out  1  payload valid
- rx_ready  in  1  FIFO accepts payload
- stall  out  1  execute stage must hold current instruction
- dout  out  DATA_W  ISR contents
- shift_count  out  CNT_W  bits shifted in, saturating

Behaviour:
- Reset: ISR=0, count=0, rx_valid=0, rx_data=0, state=IDLE, stall=0. Reset mid-WAIT or with rx_valid=1 drops the pending payload.
- slot_free = !rx_valid || rx_ready.
- Handshake:
  - rx_valid falls on rx_valid && rx_ready, independent of penable.
  - rx_data is stable while rx_valid=1.
- Decoding: shift_val = (shift==0) ? DATA_W : shift. thr = (push_thresh==0) ? DATA_W : push_thresh.
- Left shift: ISR <= upper half of {ISR, din<<(DATA_W-shift_val)} << shift_val.
- Right shift: ISR <= lower half of {din, ISR} >> shift_val.
- Counter: count_next = min(count+shift_val, DATA_W). Compute the sum in CNT_W+1 bits so it never wraps.
- Action priority in IDLE with penable=1: do_set > do_push > do_shift. Only one action per cycle.
  - do_set: ISR<=din, count<=set_count. No push.
  - do_push with slot_free: rx_data<=ISR, rx_valid<=1, ISR<=0, count<=0.
  - do_push, slot busy, push_block=0: payload discarded, ISR<=0, count<=0, no stall.
  - do_push, slot busy, push_block=1: go to WAIT.
  - do_shift: update ISR and count. If autopush_en && count_next>=thr:
    - slot_free: push the shifted value this cycle and clear ISR/count.
    - slot busy: keep the shifted ISR and count, go to WAIT.
- State IDLE: stall=0.
- State WAIT:
  - stall=1 combinationally. ISR and count hold.
  - On penable && slot_free: push ISR, clear ISR/count, return to IDLE. stall drops that cycle.
  - do_* inputs are ignored in WAIT; the execute stage re-presents them after stall.
- penable=0: no ISR, count or state change. The output handshake still completes.
- Latency: payload visible on rx_data/rx_valid one cycle after the accepting push edge.
- Back-to-back: a push is accepted in a cycle where rx_valid && rx_ready (slot reloads without a bubble).

Optional Feature:
- Macro PIO_ISR_IFFULL_EN.
- Defined:
  - Adds input push_iffull (1 bit).
  - A do_push with push_iffull=1 and count<thr is a no-op: no push, no clear, no stall.
  - When count>=thr it behaves as a normal do_push.
- Undefined: the port is absent and every do_push behaves as push_iffull=0.

Decomposition:
- Package pio_pkg holds:
  - isr_state_t enum {IDLE, WAIT}.
  - SHIFT_RIGHT/SHIFT_LEFT constants.
  - The shift-amount decode function, 0 -> DATA_W, shared with the OSR.
- One sub-module, pio_shift_merge: combinational 2*DATA_W merge-shifter (din, ISR, shift_val, dir -> new ISR). The OSR reuses it.

Test Plan:
- Left shifts, DATA_W=32, din=0xA, shift=4, x3, autopush off -> dout=0x00000AAA, shift_count=12.
- Right shifts, shift=0 with din=0xDEADBEEF -> dout=0xDEADBEEF, count=32. A further shift=8 -> count stays 32.
- Autopush with thr=8, rx_ready=1, two 4-bit shifts of 0x5 -> after 2nd shift rx_valid=1, rx_data=0x55, dout=0, count=0, stall never 1.
- Blocking push with rx_valid held, rx_ready=0, ISR=0x1234 -> stall=1 for N cycles. rx_ready=1 -> old payload taken, then rx_data=0x1234, stall=0.
- Noblock push with slot busy -> ISR=0, count=0, rx_data unchanged, stall=0. Then reset during WAIT -> rx_valid=0, stall=0 next cycle.
- With PIO_ISR_IFFULL_EN, thr=16, count=12, push_iffull=1 -> no push, ISR kept. At count=16 -> pushed.
